// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter sharing the register-file write port
// between the ALU (A) and load/store (B) writeback requesters, with a registered output stage.
module regfile_wb_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int CNT_W = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             a_valid,
    input  logic [AW-1:0]    a_rd,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [AW-1:0]    b_rd,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             wr_en,
    output logic [AW-1:0]    regW,
    output logic [WIDTH-1:0] portW,
    output logic [CNT_W-1:0] conflict_cnt
);
    logic             last_b;
    logic             grant_a;
    logic             grant_b;
    logic             xfer;
    logic [AW-1:0]    rd;
    logic [WIDTH-1:0] data;

    always_comb begin
        grant_a = !rst && !hold && a_valid && (!b_valid || last_b);
        grant_b = !rst && !hold && b_valid && (!a_valid || !last_b);
        xfer    = grant_a || grant_b;
        rd      = grant_a ? a_rd : b_rd;
        data    = grant_a ? a_data : b_data;
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    // x0 transfers still complete the handshake and move last_grant, but never write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en        <= 1'b0;
            regW         <= '0;
            portW        <= '0;
            last_b       <= 1'b1;
            conflict_cnt <= '0;
        end else begin
            wr_en <= xfer && rd != '0;
            if (xfer) begin
                regW   <= rd;
                portW  <= data;
                last_b <= grant_b;
            end
            if (a_valid && b_valid && !hold && conflict_cnt != '1)
                conflict_cnt <= conflict_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed table, corner sequences and constrained-random traffic
// checked against a round-robin reference model; a second instance uses CNT_W=4.
module tb_regfile_wb_arbiter;
    localparam int WIDTH = 32;
    localparam int AW = 5;

    logic             clk = 1'b0;
    logic             rst, hold, a_valid, b_valid;
    logic [AW-1:0]    a_rd, b_rd;
    logic [WIDTH-1:0] a_data, b_data;
    logic             a_ready, b_ready, wr_en;
    logic [AW-1:0]    regW;
    logic [WIDTH-1:0] portW;
    logic [15:0]      conflict_cnt;
    logic             a_ready4, b_ready4, wr_en4;
    logic [AW-1:0]    regW4;
    logic [WIDTH-1:0] portW4;
    logic [3:0]       cnt4;

    regfile_wb_arbiter #(.WIDTH(WIDTH), .DEPTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .wr_en(wr_en), .regW(regW), .portW(portW), .conflict_cnt(conflict_cnt)
    );

    regfile_wb_arbiter #(.WIDTH(WIDTH), .DEPTH(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .hold(hold),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready4),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready4),
        .wr_en(wr_en4), .regW(regW4), .portW(portW4), .conflict_cnt(cnt4)
    );

    always #5 clk = ~clk;

    // Register file fed only by the DUT's write port
    logic [WIDTH-1:0] rf [32];
    initial for (int i = 0; i < 32; i++) rf[i] = '0;
    always @(posedge clk) if (wr_en) rf[regW] <= portW;

    int checks = 0;
    int errors = 0;

    // Reference model: who won last, what the output stage should show, contention count
    int               m_last;
    bit               m_wr;
    logic [AW-1:0]    m_regW;
    logic [WIDTH-1:0] m_portW;
    int               m_cnt;
    bit               ga, gb, s_ar, s_br;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last = 1; m_wr = 0; m_regW = '0; m_portW = '0; m_cnt = 0;
    endtask

    task automatic cycle();
        bit both;
        both = a_valid && b_valid;
        if (hold) begin
            ga = 0; gb = 0;
        end else if (both) begin
            ga = (m_last == 1); gb = (m_last == 0);
        end else begin
            ga = a_valid; gb = b_valid;
        end
        @(negedge clk);
        s_ar = a_ready; s_br = b_ready;
        chk("a_ready", a_ready, ga);
        chk("b_ready", b_ready, gb);
        chk("a_ready4", a_ready4, ga);
        chk("b_ready4", b_ready4, gb);
        @(posedge clk);
        if (ga || gb) begin
            m_last  = gb ? 1 : 0;
            m_regW  = ga ? a_rd : b_rd;
            m_portW = ga ? a_data : b_data;
        end
        m_wr = (ga || gb) && m_regW != 0;
        if (both && !hold) m_cnt++;
        #1;
        chk("wr_en", wr_en, m_wr);
        chk("regW", regW, m_regW);
        chk("portW", portW, m_portW);
        chk("conflict_cnt", conflict_cnt, m_cnt > 65535 ? 65535 : m_cnt);
        chk("cnt4", cnt4, m_cnt > 15 ? 15 : m_cnt);
        chk("wr_en4", wr_en4, m_wr);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_wr_en", wr_en, 0);
        chk("rst_cnt", conflict_cnt, 0);
        repeat (n) @(posedge clk);
        #1;
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_wr_en_hold", wr_en, 0);
        chk("rst_cnt_hold", conflict_cnt, 0);
        rst = 1'b0;
    endtask

    typedef struct {
        bit h; bit av; logic [AW-1:0] ard; bit bv; logic [AW-1:0] brd; bit ear; bit ebr;
    } vec_t;
    vec_t tbl [13];

    initial begin
        logic [WIDTH-1:0] prev;
        tbl[0]  = '{0, 1, 3, 1, 4, 1, 0};
        tbl[1]  = '{0, 1, 3, 1, 4, 0, 1};
        tbl[2]  = '{0, 1, 3, 1, 4, 1, 0};
        tbl[3]  = '{0, 1, 3, 1, 4, 0, 1};
        tbl[4]  = '{0, 1, 3, 1, 4, 1, 0};
        tbl[5]  = '{0, 1, 3, 1, 4, 0, 1};
        tbl[6]  = '{0, 1, 7, 0, 0, 1, 0};
        tbl[7]  = '{0, 0, 0, 1, 0, 0, 1};
        tbl[8]  = '{0, 1, 3, 1, 4, 1, 0};
        tbl[9]  = '{1, 1, 3, 1, 4, 0, 0};
        tbl[10] = '{1, 1, 3, 1, 4, 0, 0};
        tbl[11] = '{1, 1, 3, 1, 4, 0, 0};
        tbl[12] = '{0, 1, 3, 1, 4, 0, 1};

        hold = 0; a_valid = 1; b_valid = 1;
        a_rd = 1; b_rd = 2; a_data = 32'h11; b_data = 32'h22;
        do_reset(5);
        cycle();
        chk("first_grant_a", s_ar, 1);

        a_valid = 0; b_valid = 0;
        do_reset(2);
        a_valid = 1; a_rd = 5; a_data = 32'hDEADBEEF;
        cycle();
        chk("single_regW", regW, 5);
        chk("single_portW", portW, 32'hDEADBEEF);
        a_valid = 0;
        cycle();
        chk("rf5", rf[5], 32'hDEADBEEF);

        do_reset(2);
        for (int i = 0; i < 13; i++) begin
            hold = tbl[i].h; a_valid = tbl[i].av; b_valid = tbl[i].bv;
            a_rd = tbl[i].ard; b_rd = tbl[i].brd;
            a_data = 32'hA0000000 | 32'(tbl[i].ard);
            b_data = tbl[i].brd == 0 ? 32'h12345678 : (32'hB0000000 | 32'(tbl[i].brd));
            cycle();
            chk($sformatf("tbl%0d_a_ready", i), s_ar, tbl[i].ear);
            chk($sformatf("tbl%0d_b_ready", i), s_br, tbl[i].ebr);
            if (i == 5) chk("contention_cnt", conflict_cnt, 6);
        end
        hold = 0; a_valid = 0; b_valid = 0;
        cycle();
        chk("rf0", rf[0], 0);
        chk("rf7", rf[7], 32'hA0000007);

        do_reset(1);
        a_valid = 1; b_valid = 1; a_rd = 6; b_rd = 8;
        repeat (20) cycle();
        chk("sat_cnt4", cnt4, 15);
        chk("cnt16", conflict_cnt, 20);

        // Reset between output-stage register and register-file commit
        a_valid = 0; b_valid = 0;
        do_reset(1);
        prev = rf[9];
        a_valid = 1; a_rd = 9; a_data = 32'h55AA55AA;
        cycle();
        a_valid = 0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_wr_en", wr_en, 0);
        chk("midrst_wr_en4", wr_en4, 0);
        @(posedge clk);
        #1;
        chk("midrst_no_commit", rf[9], prev);
        do_reset(1);

        for (int n = 0; n < 400; n++) begin
            cycle();
            if (!a_valid || ga) begin
                a_valid = $urandom_range(0, 3) != 0;
                a_rd = AW'($urandom);
                a_data = $urandom;
            end
            if (!b_valid || gb) begin
                b_valid = $urandom_range(0, 3) != 0;
                b_rd = AW'($urandom);
                b_data = $urandom;
            end
            hold = $urandom_range(0, 4) == 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
